// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared definitions for the sequential restoring divider:
//   FSM state encoding, state width and the step-counter width helper.
package seq_divider_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step
//   One combinational restoring-division step.
//   Ports:
//     i_r  [WIDTH:0]   partial remainder in
//     i_q  [WIDTH-1:0] quotient shift register in (dividend bits shift out of MSB)
//     i_d  [WIDTH-1:0] divisor
//     o_r  [WIDTH:0]   partial remainder out
//     o_q  [WIDTH-1:0] quotient shift register out (new quotient bit in LSB)
module div_restore_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_shift = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_d};
    // MSB of the trial difference is the borrow: set means divisor did not fit.
    if (!w_trial[WIDTH]) begin
      o_r = w_trial;
      o_q = {i_q[WIDTH-2:0], 1'b1};
    end else begin
      o_r = w_shift;
      o_q = {i_q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Sequential shift-subtract (restoring) unsigned divider with start/done
//   handshake. One quotient bit per clock; results held with done high.
//   Optional feature macro: DIV_ZERO_DETECT_EN (zero-divisor early-out and
//   div_by_zero flag; without it div_by_zero is tied low).
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     start        request, sampled in IDLE/DONE only
//     dividend_in  unsigned dividend, captured on accepted start
//     divisor_in   unsigned divisor, captured on accepted start
//     quotient     registered quotient, valid while done
//     remainder    registered remainder, valid while done
//     done         high in DONE state
//     busy         high in CALC state
//     div_by_zero  high with done when captured divisor was zero
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;

  logic [WIDTH:0]     w_rem_next;
  logic [WIDTH-1:0]   w_q_next;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_r (r_rem),
    .i_q (r_q),
    .i_d (r_div),
    .o_r (w_rem_next),
    .o_q (w_q_next)
  );

`ifdef DIV_ZERO_DETECT_EN
  logic r_dbz;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      r_dbz       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_q     <= dividend_in;
            r_div   <= divisor_in;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= CALC;
`ifdef DIV_ZERO_DETECT_EN
            r_dbz   <= 1'b0;
`endif
          end
        end
        CALC: begin
`ifdef DIV_ZERO_DETECT_EN
          // Zero divisor: r_q still holds the untouched dividend on the first
          // CALC edge, so the final answer is known without stepping.
          if (r_div == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_q;
            r_dbz       <= 1'b1;
            r_state     <= DONE;
          end else begin
`else
          begin
`endif
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
              r_quotient  <= w_q_next;
              r_remainder <= w_rem_next[WIDTH-1:0];
              r_state     <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign done      = (r_state == DONE);
  assign busy      = (r_state == CALC);

`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Directed self-checking bench for seq_divider (WIDTH=4), plus a full
//   operand sweep against an integer reference.
module tb_seq_divider;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  int unsigned n_checks;
  int unsigned n_pass;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  seq_divider #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Wait (bounded) for done; returns number of edges waited.
  task automatic wait_done(output int unsigned cyc);
    cyc = 0;
    while (!done && cyc < 3 * WIDTH) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int unsigned cyc,
                              input int unsigned eq, input int unsigned er,
                              input int unsigned el, input bit edbz);
    check({tag, "_lat"},  int'(cyc),         int'(el));
    check({tag, "_done"}, int'(done),        1);
    check({tag, "_busy"}, int'(busy),        0);
    check({tag, "_q"},    int'(quotient),    int'(eq));
    check({tag, "_r"},    int'(remainder),   int'(er));
    check({tag, "_dbz"},  int'(div_by_zero), int'(edbz));
  endtask

  // Issue a start at the next falling edge, check the accepting edge, run to done.
  task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                        input int unsigned eq, input int unsigned er);
    int unsigned cyc;
    int unsigned el;
    bit          early;
    early = DZ_EN && (b == 0);
    el    = early ? 1 : WIDTH;
    @(negedge clk);
    start       = 1'b1;
    dividend_in = WIDTH'(a);
    divisor_in  = WIDTH'(b);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_acc_done"}, int'(done), 0);
    check({tag, "_acc_busy"}, int'(busy), 1);
    wait_done(cyc);
    check_result(tag, cyc, eq, er, el, early);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned eq;
    int unsigned er;
    n_checks    = 0;
    n_pass      = 0;
    start       = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    rst_n       = 1'b0;

    #2;
    check("rst_done", int'(done),        0);
    check("rst_busy", int'(busy),        0);
    check("rst_q",    int'(quotient),    0);
    check("rst_r",    int'(remainder),   0);
    check("rst_dbz",  int'(div_by_zero), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 7 / 2 = 3 r1, then hold for idle cycles
    run_op("d7_2", 7, 2, 3, 1);
    repeat (6) @(posedge clk);
    #1;
    check("hold_done", int'(done),      1);
    check("hold_busy", int'(busy),      0);
    check("hold_q",    int'(quotient),  3);
    check("hold_r",    int'(remainder), 1);

    // back-to-back from DONE
    run_op("d15_15", 15, 15, 1, 0);
    run_op("d15_1",  15, 1,  15, 0);
    run_op("d3_5",   3,  5,  0, 3);

    // zero divisor
    run_op("d9_0", 9, 0, 15, 9);

    // start pulse during CALC must be ignored
    @(negedge clk);
    start       = 1'b1;
    dividend_in = 4'd12;
    divisor_in  = 4'd5;
    @(posedge clk); #1;
    check("ign_acc_busy", int'(busy), 1);
    dividend_in = 4'd1;
    divisor_in  = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check_result("ign_12_5", cyc + 1, 2, 2, WIDTH, 1'b0);

    // asynchronous reset mid-calculation
    @(negedge clk);
    start       = 1'b1;
    dividend_in = 4'd13;
    divisor_in  = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_done", int'(done),        0);
    check("arst_busy", int'(busy),        0);
    check("arst_q",    int'(quotient),    0);
    check("arst_r",    int'(remainder),   0);
    check("arst_dbz",  int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("d13_3", 13, 3, 4, 1);

    // full sweep
    for (int unsigned a = 0; a < (1 << WIDTH); a++) begin
      for (int unsigned b = 0; b < (1 << WIDTH); b++) begin
        eq = (b == 0) ? ((1 << WIDTH) - 1) : a / b;
        er = (b == 0) ? a : a % b;
        run_op($sformatf("sw%0d_%0d", a, b), a, b, eq, er);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential shift-subtract (restoring) unsigned divider; the inverse datapath of the shift-add sequential multiplier and driven through the same start/done handshake. Captures a dividend and divisor on `start`, resolves one quotient bit per clock, and holds quotient and remainder stable with `done` high until the next operation. Sits beside the multiplier in the arithmetic SoC block set.

## Interface
- `WIDTH`, 4: operand, quotient and remainder width in bits (≥2).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request; sampled only in IDLE or DONE.
- `dividend_in`  in  WIDTH: unsigned dividend, captured on the accepted `start` edge.
- `divisor_in`  in  WIDTH: unsigned divisor, captured on the accepted `start` edge.
- `quotient`  out  WIDTH: registered quotient, valid while `done`=1.
- `remainder`  out  WIDTH: registered remainder, valid while `done`=1.
- `done`  out  1: level, high in DONE state.
- `busy`  out  1: level, high in CALC state.
- `div_by_zero`  out  1: level, high with `done` when the captured divisor was 0 (see Configuration).

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `start`=1 → capture operands, clear step counter, go to CALC.
- CALC: one restoring step per edge; after step WIDTH, go to DONE. `start` is ignored.
- DONE: outputs held; `start`=1 → capture new operands and go to CALC (`done` drops on that edge). Otherwise stay.
- Datapath: partial remainder R is WIDTH+1 bits, quotient shift register Q is WIDTH bits (initially the dividend). Each step:
  - R ← {R[WIDTH-1:0], Q[WIDTH-1]}; Q ← Q<<1.
  - T = R − {0,D}, computed at WIDTH+1 bits.
  - If T's MSB is 0 (no borrow): R ← T and Q[0] ← 1; otherwise Q[0] ← 0 and R is unchanged.
- On entry to DONE: `quotient` ← Q, `remainder` ← R[WIDTH-1:0]. Both are unchanged at all other times.
- Divisor 0: result is quotient = all ones, remainder = dividend. This falls out of the algorithm naturally; the early-out feature only shortens latency.
- Reset (any state, including mid-CALC): state IDLE; R, Q and counter 0; `quotient`=0, `remainder`=0, `done`=0, `busy`=0, `div_by_zero`=0. A partial result is discarded.

## Timing
- Start accepted on edge E0 (state IDLE/DONE, `start`=1). `busy` is high from after E0 through edge E(WIDTH).
- Steps occur on edges E1..E(WIDTH). After E(WIDTH): `done`=1, `busy`=0, results valid. Latency is WIDTH cycles.
- `start` held high across multiple edges: only the first edge in IDLE/DONE is accepted. If `start` is still high when DONE is reached, a new operation begins on the next edge. `done` is then high for exactly one cycle.
- `done` and `busy` are never high simultaneously.
- Operand inputs are don't-care except on the accepting edge.

## Configuration
- `DIV_ZERO_DETECT_EN` defined:
  - A zero divisor captured on E0 skips CALC. DONE is entered at E1 with quotient = all ones, remainder = dividend and `div_by_zero`=1.
  - `div_by_zero` clears when the next start is accepted, or on reset.
- `DIV_ZERO_DETECT_EN` undefined:
  - No zero check. A zero divisor runs the full WIDTH cycles and yields the same numeric result.
  - `div_by_zero` is tied to 0.

## Structure
- Package `seq_divider_pkg`: state enum (IDLE, CALC, DONE), the state width, and a counter-width function ($clog2(WIDTH+1)).
- One sub-module, `div_restore_step`: purely combinational single restoring step with inputs R, Q, D and outputs next R, next Q. Instantiated once.
- The top module holds the FSM, step counter, operand registers and output registers.

## Test plan
- Reset asserted, then 7÷2 (WIDTH=4): `busy` high for 4 cycles, then `done`=1, quotient=3, remainder=1; outputs hold for 5+ idle cycles.
- 15÷15 → 1 r0; 15÷1 → 15 r0; 3÷5 → 0 r3. Each is issued back-to-back from DONE; `done` drops on every accepted start.
- 9÷0:
  - With `DIV_ZERO_DETECT_EN`: `done` 1 cycle after the start edge, quotient=15, remainder=9, `div_by_zero`=1.
  - Without it: `done` after 4 cycles, same values, `div_by_zero`=0.
- Start 12÷5, then pulse `start` with 1÷1 during CALC → the second start is ignored; result is 2 r2.
- Start 13÷3, drop `rst_n` after 2 cycles → all outputs 0 and IDLE immediately (asynchronous). Then 13÷3 completes to 4 r1.
- Exhaustive WIDTH=4 sweep against a reference model: every quotient/remainder matches, latency is always 4 (except the zero-divisor early-out).
